// File: rtl/scene_host_if.sv
// Object write channel into scene_host.
// Valid/ready handshake carrying a slot select and a packed record.
interface scene_host_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_sel;
    logic [55:0] wr_data;

    modport master (
        output wr_valid, wr_sel, wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_sel, wr_data,
        output wr_ready
    );
endinterface

// File: rtl/scene_host.sv
// Player view + sphere/box records, double-buffered onto one flat bus.
// Heading LUT, clamped movement, held-button auto-repeat.
module scene_host #(
    parameter int N_SPHERE   = 4,
    parameter int N_BOX      = 2,
    parameter int MOVE_SHIFT = 6,
    parameter int REPEAT_CYC = 1000000,
    parameter int X_MAX      = 639,
    parameter int Y_MAX      = 479
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] rotate_i,
    input  logic [1:0] move_i,
    input  logic       frame_sync_i,
    output logic       busy_o,
    output logic       wr_err_o,
    output logic [68+48*N_SPHERE+56*N_BOX-1:0] out_bus_o,
    scene_host_if.slave wr
);
    localparam int W   = 68 + 48*N_SPHERE + 56*N_BOX;
    localparam int CW  = $clog2(REPEAT_CYC);
    localparam int BOFS = 68 + 48*N_SPHERE;

    localparam logic       LIGHT_EN  = 1'b0;
    localparam logic [7:0] VIEW_DIST = 8'd15;
    localparam logic [7:0] POS_Z     = 8'd0;

    localparam logic [47:0] SPH0 =
        {12'hFFF, 8'd16, 10'd0, 10'd32, 8'd16};
    localparam logic [55:0] BOX0 =
        {10'd16, 10'd32, 10'd20, 10'd36, 8'd0, 8'd30};
    localparam logic [67:0] PLY0 =
        {LIGHT_EN, VIEW_DIST, 11'd0, 11'd256, 9'd0,
         10'd0, 10'd0, POS_Z};
    localparam logic [W-1:0] RST_BUS =
        (W'(BOX0) << BOFS) | (W'(SPH0) << 68) | W'(PLY0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROT,
        S_MOV
    } state_e;

    // round(256*cos(h*22.5 deg)); sin is the same table shifted by 4
    function automatic logic [10:0] cos_lut(input logic [3:0] h);
        logic [10:0] r;
        case (h)
            4'd0:    r = 11'd256;
            4'd1:    r = 11'd237;
            4'd2:    r = 11'd181;
            4'd3:    r = 11'd98;
            4'd4:    r = 11'd0;
            4'd5:    r = -11'd98;
            4'd6:    r = -11'd181;
            4'd7:    r = -11'd237;
            4'd8:    r = -11'd256;
            4'd9:    r = -11'd237;
            4'd10:   r = -11'd181;
            4'd11:   r = -11'd98;
            4'd12:   r = 11'd0;
            4'd13:   r = 11'd98;
            4'd14:   r = 11'd181;
            default: r = 11'd237;
        endcase
        return r;
    endfunction

    function automatic logic [9:0] clamp(
        input logic [11:0] v,
        input int          hi
    );
        logic [9:0] r;
        if (v[11])
            r = 10'd0;
        else if (int'(v) > hi)
            r = 10'(hi);
        else
            r = v[9:0];
        return r;
    endfunction

    state_e        state_q, state_d;
    logic          busy, do_rot, do_mov, idle;
    logic [3:0]    heading_q, heading_d;
    logic [9:0]    pos_x_q, pos_x_d;
    logic [9:0]    pos_y_q, pos_y_d;
    logic [1:0]    rot_q, mov_q;
    logic [3:0]    in_prev_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          err_q;
    logic [W-1:0]  bus_q, bus_d;
    logic [47:0]   sph_q [N_SPHERE];
    logic [55:0]   box_q [N_BOX];

    logic [3:0]  in_now;
    logic        in_chg, in_held, rep_hit, trig, accept;
    logic        commit;
    logic        wr_fire, is_box, bad_idx;
    logic [3:0]  idx;
    logic [10:0] dx, dy;
    logic signed [11:0] ddx, ddy, nx, ny;

    assign in_now  = {rotate_i, move_i};
    assign in_chg  = in_now != in_prev_q;
    assign in_held = in_now != 4'd0;
    assign rep_hit = !in_chg && in_held &&
                     (cnt_q == CW'(REPEAT_CYC - 1));
    assign trig    = (in_chg && in_held) || rep_hit;
    assign accept  = trig && idle;

    always_comb begin
        if (in_chg || trig || !in_held)
            cnt_d = '0;
        else
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_d = S_ROT;
            S_ROT:   state_d = S_MOV;
            S_MOV:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = 1'b0;
        do_rot = 1'b0;
        do_mov = 1'b0;
        idle   = 1'b0;
        unique case (state_q)
            S_IDLE: idle = 1'b1;
            S_ROT: begin
                busy   = 1'b1;
                do_rot = 1'b1;
            end
            S_MOV: begin
                busy   = 1'b1;
                do_mov = 1'b1;
            end
            default: idle = 1'b1;
        endcase
    end

    assign dx = cos_lut(heading_q);
    assign dy = cos_lut(heading_q - 4'd4);

    always_comb begin
        ddx = $signed({dx[10], dx}) >>> MOVE_SHIFT;
        ddy = $signed({dy[10], dy}) >>> MOVE_SHIFT;
        nx  = $signed({2'b00, pos_x_q});
        ny  = $signed({2'b00, pos_y_q});
        if (mov_q == 2'b10) begin
            nx = nx + ddx;
            ny = ny + ddy;
        end else if (mov_q == 2'b01) begin
            nx = nx - ddx;
            ny = ny - ddy;
        end
    end

    always_comb begin
        heading_d = heading_q;
        if (do_rot && rot_q == 2'b01)
            heading_d = heading_q - 4'd1;
        else if (do_rot && rot_q == 2'b10)
            heading_d = heading_q + 4'd1;
        pos_x_d = do_mov ? clamp(nx, X_MAX) : pos_x_q;
        pos_y_d = do_mov ? clamp(ny, Y_MAX) : pos_y_q;
    end

    // A commit waits for IDLE so a half-applied command is never shown
    assign commit = idle && (frame_sync_i || pend_q);

    always_comb begin
        pend_d = pend_q;
        if (commit)
            pend_d = 1'b0;
        else if (frame_sync_i && busy)
            pend_d = 1'b1;
    end

    assign wr.wr_ready = !commit;
    assign wr_fire = wr.wr_valid && wr.wr_ready;
    assign is_box  = wr.wr_sel[4];
    assign idx     = wr.wr_sel[3:0];
    assign bad_idx = is_box ? (32'(idx) >= N_BOX)
                            : (32'(idx) >= N_SPHERE);

    always_comb begin
        bus_d = '0;
        bus_d[67:0] = {LIGHT_EN, VIEW_DIST, dx, dy, 9'd0,
                       pos_x_q, pos_y_q, POS_Z};
        for (int i = 0; i < N_SPHERE; i++)
            bus_d[68 + 48*i +: 48] = sph_q[i];
        for (int i = 0; i < N_BOX; i++)
            bus_d[BOFS + 56*i +: 56] = box_q[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            heading_q <= 4'd4;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            rot_q     <= '0;
            mov_q     <= '0;
            in_prev_q <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
            bus_q     <= RST_BUS;
        end else begin
            heading_q <= heading_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            in_prev_q <= in_now;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            if (accept) begin
                rot_q <= rotate_i;
                mov_q <= move_i;
            end
            if (wr_fire && bad_idx)
                err_q <= 1'b1;
            if (commit)
                bus_q <= bus_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_SPHERE; i++)
                sph_q[i] <= (i == 0) ? SPH0 : '0;
        end else if (wr_fire && !is_box) begin
            for (int i = 0; i < N_SPHERE; i++)
                if (idx == 4'(i))
                    sph_q[i] <= wr.wr_data[47:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_BOX; i++)
                box_q[i] <= (i == 0) ? BOX0 : '0;
        end else if (wr_fire && is_box) begin
            for (int i = 0; i < N_BOX; i++)
                if (idx == 4'(i))
                    box_q[i] <= wr.wr_data;
        end
    end

    assign busy_o    = busy;
    assign wr_err_o  = err_q;
    assign out_bus_o = bus_q;
endmodule

// File: tb/tb_scene_host.sv
// Directed bench for scene_host: reset image, rotate/move, clamping,
// auto-repeat, object writes, and commit deferral across busy.
module tb_scene_host;
    localparam int NS = 4;
    localparam int NB = 2;
    localparam int W  = 68 + 48*NS + 56*NB;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   rotate;
    logic [1:0]   move;
    logic         frame_sync;
    logic         busy;
    logic         wr_err;
    logic [W-1:0] out_bus;

    scene_host_if wif();

    scene_host #(
        .N_SPHERE  (NS),
        .N_BOX     (NB),
        .MOVE_SHIFT(6),
        .REPEAT_CYC(8),
        .X_MAX     (639),
        .Y_MAX     (479)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rotate_i    (rotate),
        .move_i      (move),
        .frame_sync_i(frame_sync),
        .busy_o      (busy),
        .wr_err_o    (wr_err),
        .out_bus_o   (out_bus),
        .wr          (wif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [47:0] es [NS];
    logic [55:0] eb [NB];
    logic [67:0] ep;

    function automatic logic [67:0] ply(
        input logic [10:0] dx,
        input logic [10:0] dy,
        input logic [9:0]  x,
        input logic [9:0]  y
    );
        return {1'b0, 8'd15, dx, dy, 9'd0, x, y, 8'd0};
    endfunction

    task automatic chk(
        input string        tag,
        input logic [W-1:0] obs,
        input logic [W-1:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h",
                   tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag);
        logic [W-1:0] e;
        e = '0;
        e[67:0] = ep;
        for (int i = 0; i < NS; i++)
            e[68 + 48*i +: 48] = es[i];
        for (int i = 0; i < NB; i++)
            e[68 + 48*NS + 56*i +: 56] = eb[i];
        chk(tag, out_bus, e);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) es[i] = '0;
        for (int i = 0; i < NB; i++) eb[i] = '0;
        es[0] = {12'hFFF, 8'd16, 10'd0, 10'd32, 8'd16};
        eb[0] = {10'd16, 10'd32, 10'd20, 10'd36, 8'd0, 8'd30};
        ep    = ply(11'd0, 11'd256, 10'd0, 10'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic commit();
        frame_sync = 1'b1;
        @(negedge clk);
        frame_sync = 1'b0;
    endtask

    task automatic pulse(input logic [1:0] r, input logic [1:0] m);
        rotate = r;
        move   = m;
        @(negedge clk);
        rotate = 2'b00;
        move   = 2'b00;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        rotate       = 2'b00;
        move         = 2'b00;
        frame_sync   = 1'b0;
        wif.wr_valid = 1'b0;
        wif.wr_sel   = '0;
        wif.wr_data  = '0;
        @(negedge clk);
        do_reset();

        chk_bus("reset_bus");
        chk("reset_busy", W'(busy), W'(0));
        chk("reset_err", W'(wr_err), W'(0));
        chk("reset_ready", W'(wif.wr_ready), W'(1));

        frame_sync = 1'b1;
        #1 chk("commit_ready", W'(wif.wr_ready), W'(0));
        @(negedge clk);
        frame_sync = 1'b0;
        chk_bus("reset_commit");

        rotate = 2'b10;
        @(negedge clk);
        rotate = 2'b00;
        chk("rot_busy1", W'(busy), W'(1));
        @(negedge clk);
        chk("rot_busy2", W'(busy), W'(1));
        @(negedge clk);
        chk("rot_busy3", W'(busy), W'(0));
        chk_bus("rot_nocommit");
        commit();
        ep = ply(-11'd98, 11'd237, 10'd0, 10'd0);
        chk_bus("rot_left_h5");

        do_reset();
        pulse(2'b00, 2'b01);
        commit();
        chk_bus("back_clamp_y0");
        for (int i = 0; i < 3; i++)
            pulse(2'b00, 2'b10);
        commit();
        ep = ply(11'd0, 11'd256, 10'd0, 10'd12);
        chk_bus("fwd3_y12");

        move = 2'b10;
        for (int k = 0; k <= 20; k++) begin
            chk($sformatf("repeat_busy_k%0d", k), W'(busy),
                W'((k > 0) && ((k % 8 == 1) || (k % 8 == 2))));
            @(negedge clk);
        end
        move = 2'b00;
        @(negedge clk);
        @(negedge clk);
        commit();
        ep = ply(11'd0, 11'd256, 10'd0, 10'd24);
        chk_bus("repeat_y24");

        wif.wr_valid = 1'b1;
        wif.wr_sel   = 5'b00010;
        wif.wr_data  = {8'h00, 12'hF00, 8'd8,
                        10'd100, 10'd200, 8'd5};
        #1 chk("wr_ready_idle", W'(wif.wr_ready), W'(1));
        @(negedge clk);
        wif.wr_sel  = 5'b10001;
        wif.wr_data = {10'd1, 10'd2, 10'd3, 10'd4, 8'd5, 8'd6};
        @(negedge clk);
        wif.wr_valid = 1'b0;
        chk_bus("wr_before_commit");
        es[2] = {12'hF00, 8'd8, 10'd100, 10'd200, 8'd5};
        eb[1] = {10'd1, 10'd2, 10'd3, 10'd4, 8'd5, 8'd6};
        commit();
        chk_bus("wr_after_commit");
        chk("wr_err_clean", W'(wr_err), W'(0));

        wif.wr_valid = 1'b1;
        wif.wr_sel   = 5'b01001;
        wif.wr_data  = {56{1'b1}};
        @(negedge clk);
        wif.wr_valid = 1'b0;
        chk("wr_err_set", W'(wr_err), W'(1));
        commit();
        chk_bus("wr_bad_discard");
        chk("wr_err_sticky", W'(wr_err), W'(1));

        rotate = 2'b01;
        move   = 2'b10;
        @(negedge clk);
        rotate     = 2'b00;
        move       = 2'b00;
        frame_sync = 1'b1;
        #1 chk("pend_ready_busy", W'(wif.wr_ready), W'(1));
        @(negedge clk);
        frame_sync = 1'b0;
        chk_bus("pend_no_early");
        @(negedge clk);
        chk("pend_commit_rdy", W'(wif.wr_ready), W'(0));
        chk_bus("pend_still_old");
        @(negedge clk);
        ep = ply(11'd98, 11'd237, 10'd1, 10'd27);
        chk_bus("pend_rot_mov");
        chk("pend_cleared", W'(wif.wr_ready), W'(1));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
